// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
// ALU results pass straight to writeback with one cycle of latency.
// Loads and stores issue a single request on the data memory port and
// stall upstream until the request is acknowledged or times out.
// Optional build macro: MEM_ALIGN_CHECK_EN
//   When defined, loads/stores to odd addresses are rejected without
//   touching memory and reported through mem_err.

module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    // execute stage interface
    input  logic        ixmem_valid_p1,
    input  logic [15:0] alu_output_data_p1,
    input  logic [15:0] st_data_p1,
    input  logic        ld_valid_p1,
    input  logic        st_valid_p1,
    input  logic [2:0]  dest_reg_p1,
    input  logic        reg_write_valid_p1,

    // data memory interface
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,

    // pipeline control
    output logic        mem_stall,

    // writeback bundle
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_dest_reg,
    output logic [15:0] wb_data,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // wait counter compares against the timeout in its own 8-bit width
    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // outstanding memory request
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    // instruction context kept while the request is outstanding
    logic        is_load_q, is_load_d;
    logic [2:0]  dest_q, dest_d;
    logic        rw_q, rw_d;

    // writeback registers
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [2:0]  wb_dest_q, wb_dest_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        mem_err_q, mem_err_d;

    logic        is_mem_op;
    logic        misaligned;

    assign is_mem_op = ld_valid_p1 | st_valid_p1;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = alu_output_data_p1[0];
`else
    assign misaligned = 1'b0;
`endif

    // next-state, request and writeback computation
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_load_d      = is_load_q;
        dest_d         = dest_q;
        rw_d           = rw_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        mem_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ixmem_valid_p1) begin
                    if (is_mem_op && misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = dest_reg_p1;
                        mem_err_d  = 1'b1;
                    end else if (is_mem_op) begin
                        state_d   = WAIT;
                        cnt_d     = 8'd1;
                        req_d     = 1'b1;
                        we_d      = st_valid_p1;
                        addr_d    = alu_output_data_p1;
                        wdata_d   = st_data_p1;
                        is_load_d = ld_valid_p1;
                        dest_d    = dest_reg_p1;
                        rw_d      = reg_write_valid_p1;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = reg_write_valid_p1;
                        wb_dest_d      = dest_reg_p1;
                        wb_data_d      = alu_output_data_p1;
                    end
                end
            end

            WAIT: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    cnt_d      = 8'd0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    if (is_load_q) begin
                        wb_data_d      = dmem_rdata;
                        wb_reg_write_d = rw_q;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d    = IDLE;
                    cnt_d      = 8'd0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 16'd0;
            wdata_q        <= 16'd0;
            is_load_q      <= 1'b0;
            dest_q         <= 3'd0;
            rw_q           <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dest_q      <= 3'd0;
            wb_data_q      <= 16'd0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            is_load_q      <= is_load_d;
            dest_q         <= dest_d;
            rw_q           <= rw_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign mem_stall    = (state_q == WAIT);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_dest_reg  = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// The driver issues instructions and plays the memory, pushing the
// expected writeback for each instruction into a queue; a monitor on the
// falling edge pops and compares whenever wb_valid is seen.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the alignment check.

module tb_mem_stage;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        ixmem_valid_p1;
    logic [15:0] alu_output_data_p1;
    logic [15:0] st_data_p1;
    logic        ld_valid_p1;
    logic        st_valid_p1;
    logic [2:0]  dest_reg_p1;
    logic        reg_write_valid_p1;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_dest_reg;
    logic [15:0] wb_data;
    logic        mem_err;

    typedef struct {
        bit          chkData;
        bit          chkDest;
        logic [15:0] data;
        logic [2:0]  dest;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   failCount  = 0;

    mem_stage #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .ixmem_valid_p1     (ixmem_valid_p1),
        .alu_output_data_p1 (alu_output_data_p1),
        .st_data_p1         (st_data_p1),
        .ld_valid_p1        (ld_valid_p1),
        .st_valid_p1        (st_valid_p1),
        .dest_reg_p1        (dest_reg_p1),
        .reg_write_valid_p1 (reg_write_valid_p1),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .mem_stall          (mem_stall),
        .wb_valid           (wb_valid),
        .wb_reg_write       (wb_reg_write),
        .wb_dest_reg        (wb_dest_reg),
        .wb_data            (wb_data),
        .mem_err            (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveGarbage();
        int r;
        r = $urandom_range(0, 2);
        ixmem_valid_p1     = 1'($urandom_range(0, 1));
        alu_output_data_p1 = 16'($urandom);
        st_data_p1         = 16'($urandom);
        ld_valid_p1        = (r == 1);
        st_valid_p1        = (r == 2);
        dest_reg_p1        = 3'($urandom);
        reg_write_valid_p1 = 1'($urandom_range(0, 1));
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store.
    // ackCycle: WAIT cycle (1-based) on which the memory acknowledges;
    // anything above TIMEOUT means the memory never answers.
    task automatic applyStimulus(input int kind, input logic [15:0] alu,
                                 input logic [15:0] sd, input logic [2:0] dest,
                                 input logic rw, input int ackCycle,
                                 input logic [15:0] rdata);
        exp_t e;
        bit   isMem;
        bit   misaligned;
        bit   done;
        isMem      = (kind != 0);
        misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = isMem && alu[0];
`endif
        e.chkData = 1'b0;
        e.chkDest = 1'b0;
        e.data    = 16'd0;
        e.dest    = 3'd0;
        e.rw      = 1'b0;
        e.err     = 1'b0;
        if (!isMem) begin
            e.chkData = 1'b1;
            e.chkDest = 1'b1;
            e.data    = alu;
            e.dest    = dest;
            e.rw      = rw;
        end else if (misaligned) begin
            e.err = 1'b1;
        end else if (ackCycle <= TIMEOUT) begin
            if (kind == 1) begin
                e.chkData = 1'b1;
                e.chkDest = 1'b1;
                e.data    = rdata;
                e.dest    = dest;
                e.rw      = rw;
            end
        end else begin
            e.err = 1'b1;
        end
        expQ.push_back(e);

        checkOutput("stall_at_issue", 16'(mem_stall), 16'd0);
        dmem_ack           = 1'b0;
        ixmem_valid_p1     = 1'b1;
        alu_output_data_p1 = alu;
        st_data_p1         = sd;
        ld_valid_p1        = (kind == 1);
        st_valid_p1        = (kind == 2);
        dest_reg_p1        = dest;
        reg_write_valid_p1 = rw;
        @(posedge clk); #1;
        ixmem_valid_p1 = 1'b0;
        ld_valid_p1    = 1'b0;
        st_valid_p1    = 1'b0;

        if (isMem && !misaligned) begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT && !done; k++) begin
                checkOutput("req_in_wait", 16'(dmem_req), 16'd1);
                checkOutput("stall_in_wait", 16'(mem_stall), 16'd1);
                checkOutput("addr_stable", dmem_addr, alu);
                checkOutput("we_stable", 16'(dmem_we), 16'(kind == 2));
                if (kind == 2)
                    checkOutput("wdata_stable", dmem_wdata, sd);
                driveGarbage();
                if (k == ackCycle) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = 16'($urandom);
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (k == ackCycle) done = 1'b1;
            end
            ixmem_valid_p1 = 1'b0;
            ld_valid_p1    = 1'b0;
            st_valid_p1    = 1'b0;
        end
        checkOutput("req_after", 16'(dmem_req), 16'd0);
        checkOutput("stall_after", 16'(mem_stall), 16'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 16'(dmem_req), 16'd0);
        checkOutput({tag, "_we"}, 16'(dmem_we), 16'd0);
        checkOutput({tag, "_addr"}, dmem_addr, 16'd0);
        checkOutput({tag, "_wdata"}, dmem_wdata, 16'd0);
        checkOutput({tag, "_stall"}, 16'(mem_stall), 16'd0);
        checkOutput({tag, "_wb_valid"}, 16'(wb_valid), 16'd0);
        checkOutput({tag, "_wb_rw"}, 16'(wb_reg_write), 16'd0);
        checkOutput({tag, "_wb_dest"}, 16'(wb_dest_reg), 16'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 16'd0);
        checkOutput({tag, "_err"}, 16'(mem_err), 16'd0);
    endtask

    // Scoreboard monitor: compares every writeback against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wb_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wb", 16'(wb_valid), 16'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wb_reg_write", 16'(wb_reg_write), 16'(e.rw));
                    checkOutput("wb_mem_err", 16'(mem_err), 16'(e.err));
                    if (e.chkData) checkOutput("wb_data", wb_data, e.data);
                    if (e.chkDest) checkOutput("wb_dest", 16'(wb_dest_reg), 16'(e.dest));
                end
            end else begin
                checkOutput("idle_reg_write", 16'(wb_reg_write), 16'd0);
                checkOutput("idle_mem_err", 16'(mem_err), 16'd0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence: directed cases followed by random traffic
    initial begin
        int kind;
        int gap;
        rst                = 1'b1;
        ixmem_valid_p1     = 1'b0;
        alu_output_data_p1 = 16'd0;
        st_data_p1         = 16'd0;
        ld_valid_p1        = 1'b0;
        st_valid_p1        = 1'b0;
        dest_reg_p1        = 3'd0;
        reg_write_valid_p1 = 1'b0;
        dmem_ack           = 1'b0;
        dmem_rdata         = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed cases");
        applyStimulus(0, 16'h1234, 16'h0000, 3'd3, 1'b1, 0, 16'h0000);
        applyStimulus(1, 16'h0040, 16'h0000, 3'd5, 1'b1, 3, 16'hBEEF);
        applyStimulus(2, 16'h0010, 16'h00AA, 3'd2, 1'b1, 1, 16'h0000);
        applyStimulus(1, 16'h0080, 16'h0000, 3'd1, 1'b1, TIMEOUT + 1, 16'h5555);
        applyStimulus(1, 16'h0082, 16'h0000, 3'd6, 1'b1, TIMEOUT, 16'hCAFE);
        applyStimulus(1, 16'h0041, 16'h0000, 3'd4, 1'b1, 2, 16'h7777);
        applyStimulus(0, 16'hA5A5, 16'h0000, 3'd7, 1'b0, 0, 16'h0000);

        // reset during the second WAIT cycle of a load
        ixmem_valid_p1     = 1'b1;
        alu_output_data_p1 = 16'h0100;
        ld_valid_p1        = 1'b1;
        st_valid_p1        = 1'b0;
        dest_reg_p1        = 3'd2;
        reg_write_valid_p1 = 1'b1;
        @(posedge clk); #1;
        ixmem_valid_p1 = 1'b0;
        ld_valid_p1    = 1'b0;
        checkOutput("rst_wait_req", 16'(dmem_req), 16'd1);
        @(posedge clk); #1;
        checkOutput("rst_wait_stall", 16'(mem_stall), 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetState("mid_wait_reset");
        @(posedge clk); #1;

        $display("[TB] random traffic");
        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = 16'($urandom);
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
            kind = $urandom_range(0, 2);
            applyStimulus(kind, 16'($urandom), 16'($urandom), 3'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(1, TIMEOUT + 1),
                          16'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, meaning max WAIT cycles without dmem_ack before abort (range 2..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ixmem_valid_p1  input  1  execute stage presents a valid instruction.
REQ-005 alu_output_data_p1  input  16  ALU result; memory address for LD/ST.
REQ-006 st_data_p1  input  16  store data.
REQ-007 ld_valid_p1 / st_valid_p1  input  1 each  instruction is load / store (never both).
REQ-008 dest_reg_p1  input  3  destination register; reg_write_valid_p1  input  1  writes a register.
REQ-009 dmem_req  output  1  memory request; dmem_we  output  1  store when 1.
REQ-010 dmem_addr / dmem_wdata  output  16 each  request address / store data.
REQ-011 dmem_ack  input  1  request complete; dmem_rdata  input  16  load data, valid with ack.
REQ-012 mem_stall  output  1  upstream holds its outputs while 1.
REQ-013 wb_valid  output  1; wb_reg_write  output  1; wb_dest_reg  output  3; wb_data  output  16  writeback bundle.
REQ-014 mem_err  output  1  one-cycle pulse on aborted access.

Function
REQ-015 FSM states IDLE, WAIT; mem_stall SHALL equal (state==WAIT), combinationally.
REQ-016 IDLE, ixmem_valid_p1=1, no LD/ST: next cycle wb_valid=1, wb_data=alu_output_data_p1, wb_dest_reg/wb_reg_write captured; latency 1.
REQ-017 IDLE, ixmem_valid_p1=1 with LD or ST: capture addr, wdata, we, dest; next cycle state=WAIT, dmem_req=1, wb_valid=0.
REQ-018 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL remain stable until dmem_ack sampled 1; inputs from upstream ignored.
REQ-019 WAIT with dmem_ack=1: next cycle dmem_req=0, state=IDLE, wb_valid=1; load: wb_data=dmem_rdata, wb_reg_write=captured; store: wb_reg_write=0.
REQ-020 WAIT cycle counter (8-bit) counts from 1 on WAIT entry; on ACK_TIMEOUT-th WAIT cycle with dmem_ack=0: next cycle dmem_req=0, state=IDLE, mem_err=1, wb_valid=1, wb_reg_write=0.
REQ-021 dmem_ack on the timeout cycle: ack wins, no mem_err.
REQ-022 dmem_ack while IDLE SHALL be ignored.
REQ-023 wb_valid, mem_err SHALL be single-cycle pulses per instruction; outputs hold last value otherwise, with wb_reg_write forced 0 when wb_valid=0.
REQ-024 Back-to-back: instruction presented in the cycle WAIT exits is not accepted (mem_stall=1 that cycle); accepted the following cycle.
REQ-025 dmem_req SHALL be driven from a flop, never combinationally from inputs.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_reg_write=0, wb_dest_reg=0, wb_data=0, mem_err=0.
REQ-027 Reset mid-WAIT SHALL drop dmem_req next cycle with no writeback and no mem_err.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: LD/ST with alu_output_data_p1[0]=1 SHALL not issue dmem_req; next cycle wb_valid=1, wb_reg_write=0, mem_err=1, state stays IDLE.
REQ-029 MEM_ALIGN_CHECK_EN undefined: no alignment check; odd addresses issue normally.

Verification
REQ-030 ALU op, alu=16'h1234, dest=3, rw=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_dest_reg=3, mem_stall never 1.
REQ-031 LD addr=16'h0040, ack after 3 WAIT cycles with rdata=16'hBEEF -> mem_stall=1 for 3 cycles, addr stable, then wb_data=16'hBEEF, wb_reg_write=1.
REQ-032 ST addr=16'h0010, data=16'h00AA, ack immediately -> dmem_we=1, dmem_wdata=16'h00AA for one WAIT cycle, wb_reg_write=0.
REQ-033 LD, no ack, ACK_TIMEOUT=4 -> dmem_req high 4 cycles, then mem_err pulse, wb_reg_write=0; ack on 4th cycle instead -> normal load, no mem_err.
REQ-034 rst asserted in 2nd WAIT cycle -> next cycle dmem_req=0, wb_valid=0, mem_err=0, all outputs at reset values.
REQ-035 MEM_ALIGN_CHECK_EN defined, LD addr=16'h0041 -> dmem_req stays 0, mem_err=1 one cycle; undefined -> dmem_req=1, dmem_addr=16'h0041.
